tns_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one 22-bit TNS encoder (TNS_encoder_22) among N_LANES requesters.
- Serialises accepted words into a single encoder input stream, so the encoder's choice-bit history (r_bit) follows one coherent bus sequence.
- After reset, primes the encoder to a defined history before first use.
- Tags every codeword with its source lane and end-of-packet flag, aligned to the encoder's output.

---
 rtl/tns_sched_pkg.sv | 26 ++
 rtl/tns_rr_arbiter.sv | 32 +++
 rtl/tns_tx_scheduler.sv | 119 +++++++++++
 tb/tb_tns_tx_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tns_sched_pkg.sv
// Shared types and constants for the TNS transmit scheduler.
// Lane-tag width must track the top-level LANE_W.
package tns_sched_pkg;

  localparam int BLEN08       = 8;
  localparam int CODE_BITS    = 22;
  localparam int PRIME_CYCLES = 2;
  localparam int TAG_LANE_W   = 2;

  typedef enum logic [1:0] {
    S_PRIME,
    S_IDLE,
    S_BURST
  } sched_state_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_LANE_W-1:0] lane;
    logic                  last;
  } tag_t;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/tns_rr_arbiter.sv
// Rotating-priority pick: first valid lane at or above ptr,
// wrapping modulo N_LANES.
module tns_rr_arbiter #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = 2
) (
  input  logic [N_LANES-1:0] valid,
  input  logic [LANE_W-1:0]  ptr,
  output logic [LANE_W-1:0]  idx,
  output logic               any
);

  int                j;
  logic [LANE_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    j    = 0;
    cand = '0;
    for (int i = 0; i < N_LANES; i++) begin
      j = int'(ptr) + i;
      if (j >= N_LANES) j = j - N_LANES;
      cand = LANE_W'(j);
      if (!any && valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/tns_tx_scheduler.sv
// Round-robin front end sharing one TNS_encoder_22 among N_LANES
// requesters; tags each codeword with its lane and end-of-packet.
module tns_tx_scheduler
  import tns_sched_pkg::*;
#(
  parameter int N_LANES   = 4,
  parameter int LANE_W    = 2,
  parameter int DATA_W    = BLEN08,
  parameter int CODE_W    = CODE_BITS,
  parameter int MAX_BURST = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_LANES-1:0]        req_valid,
  input  logic [N_LANES*DATA_W-1:0] req_data,
  input  logic [N_LANES-1:0]        req_last,
  output logic [N_LANES-1:0]        req_ready,
  output logic [DATA_W-1:0]         enc_datain,
  input  logic [CODE_W-1:0]         enc_codeout,
  output logic [CODE_W-1:0]         code_out,
  output logic                      code_valid,
  output logic [LANE_W-1:0]         code_lane,
  output logic                      code_last,
  output logic                      busy
);

  sched_state_e      state;
  logic [1:0]        prime_cnt;
  logic [7:0]        burst_cnt;
  logic [LANE_W-1:0] rr_ptr;
  logic [LANE_W-1:0] grant;
  logic [LANE_W-1:0] arb_idx;
  logic [LANE_W-1:0] next_ptr;
  logic              arb_any;
  logic              grant_valid;
  logic              grant_last;
  logic [DATA_W-1:0] grant_data;
  logic              accept;
  logic              burst_end;
  tag_t              tag_q1;
  tag_t              tag_q2;

  tns_rr_arbiter #(
    .N_LANES(N_LANES),
    .LANE_W (LANE_W)
  ) u_arb (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign grant_valid = req_valid[grant];
  assign grant_last  = req_last[grant];
  assign grant_data  = req_data[grant*DATA_W +: DATA_W];
  assign accept      = (state == S_BURST) && grant_valid;
  assign next_ptr    = LANE_W'(wrap_inc(int'(grant), N_LANES));

  // A dropped valid ends the burst without consuming anything.
  assign burst_end = (state == S_BURST) &&
                     (!grant_valid || grant_last ||
                      (burst_cnt + 8'd1 == 8'(MAX_BURST)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_PRIME;
      prime_cnt  <= '0;
      rr_ptr     <= '0;
      grant      <= '0;
      burst_cnt  <= '0;
      enc_datain <= '0;
      req_ready  <= '0;
      tag_q1     <= '0;
      tag_q2     <= '0;
    end else begin
      tag_q1 <= '0;
      tag_q2 <= tag_q1;
      unique case (state)
        S_PRIME: begin
          enc_datain <= '0;
          if (prime_cnt == 2'(PRIME_CYCLES - 1))
            state <= S_IDLE;
          else
            prime_cnt <= prime_cnt + 2'd1;
        end
        S_IDLE: begin
          if (arb_any) begin
            grant     <= arb_idx;
            burst_cnt <= '0;
            req_ready <= N_LANES'(1) << arb_idx;
            state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (accept) begin
            enc_datain <= grant_data;
            burst_cnt  <= burst_cnt + 8'd1;
            tag_q1     <= '{valid: 1'b1,
                            lane:  TAG_LANE_W'(grant),
                            last:  grant_last};
          end
          if (burst_end) begin
            req_ready <= '0;
            rr_ptr    <= next_ptr;
            state     <= S_IDLE;
          end
        end
        default: state <= S_PRIME;
      endcase
    end
  end

  assign code_out   = enc_codeout;
  assign code_valid = tag_q2.valid;
  assign code_lane  = LANE_W'(tag_q2.lane);
  assign code_last  = tag_q2.last;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_tns_tx_scheduler.sv
// Bench for tns_tx_scheduler with a stand-in registered encoder;
// table vectors, directed corner cases and a randomized packet model.
module tb_tns_tx_scheduler;

  localparam int NL = 4;
  localparam int MB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  enc_datain;
  logic [21:0] enc_codeout;
  logic [21:0] code_out;
  logic        code_valid;
  logic [1:0]  code_lane;
  logic        code_last;
  logic        busy;
  logic [21:0] enc_reg;

  tns_tx_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .enc_datain (enc_datain),
    .enc_codeout(enc_codeout),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_lane  (code_lane),
    .code_last  (code_last),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [21:0] enc_f(input logic [7:0] d);
    return {6'h15, ~d, d};
  endfunction

  // stand-in for TNS_encoder_22: one register stage
  always @(posedge clock) enc_reg <= enc_f(enc_datain);
  assign enc_codeout = enc_reg;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp, output bit ok);
    n_chk++;
    ok = (act === exp);
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic c(input string nm, input logic [31:0] act,
                   input logic [31:0] exp);
    bit ok;
    chk(nm, act, exp, ok);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [7:0] d;
    logic       l;
    logic       busy;
    logic [3:0] rdy;
    logic [7:0] enc;
    logic       cv;
    logic [1:0] lane;
    logic       last;
    logic [7:0] cd;
  } vec_t;

  vec_t tv[10];

  logic [7:0] wd[4][64];
  logic       wl[4][64];
  int         wcnt[4];
  int         wptr[4];
  bit         hold[4];
  logic [3:0] pend;
  bit         drop_on;

  logic [1:0]  obs_lane[1024];
  logic        obs_last[1024];
  logic [21:0] obs_code[1024];
  int          obs_cyc[1024];
  int          obs_n;
  logic [7:0]  enc_hist[8192];
  int          cyc = 0;

  logic [1:0] exp_lane[1024];
  logic       exp_last[1024];
  logic [7:0] exp_d[1024];
  int         exp_n;

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) begin
      wcnt[i] = 0;
      wptr[i] = 0;
      hold[i] = 1'b0;
    end
    drop_on = 1'b0;
    pend    = '0;
    obs_n   = 0;
  endtask

  task automatic add_packet(input int l, input int len,
                            input logic [7:0] base, input bit rnd);
    for (int k = 0; k < len; k++) begin
      wd[l][wcnt[l]] = rnd ? 8'($urandom) : base + 8'(k);
      wl[l][wcnt[l]] = (k == len - 1);
      wcnt[l]++;
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < 4; i++) begin
      if (wptr[i] < wcnt[i] && !hold[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = wd[i][wptr[i]];
        req_last[i]        = wl[i][wptr[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    if (code_valid && obs_n < 1024) begin
      obs_lane[obs_n] = code_lane;
      obs_last[obs_n] = code_last;
      obs_code[obs_n] = code_out;
      obs_cyc[obs_n]  = cyc;
      obs_n++;
    end
    if (cyc < 8192) enc_hist[cyc] = enc_datain;
    for (int i = 0; i < 4; i++)
      if (pend[i]) wptr[i]++;
    if (drop_on) hold[1] = (wptr[1] >= 2) && (wptr[2] < wcnt[2]);
    drive_lanes();
    pend = reset ? 4'b0 : (req_ready & req_valid);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend  = '0;
    repeat (3) cycle();
    reset = 1'b0;
    obs_n = 0;
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (obs_n < n && k < budget) begin
      cycle();
      k++;
    end
    repeat (6) cycle();
  endtask

  // Transaction-level view: lanes served in pointer order, each grant
  // takes words until end of packet, MAX_BURST, or the lane runs dry.
  task automatic build_model();
    int p;
    int rp[4];
    int l;
    int n;
    bit done;
    p = 0;
    exp_n = 0;
    for (int i = 0; i < 4; i++) rp[i] = wptr[i];
    forever begin
      l = -1;
      for (int k = 0; k < NL; k++)
        if (l < 0 && rp[(p + k) % NL] < wcnt[(p + k) % NL])
          l = (p + k) % NL;
      if (l < 0) break;
      n = 0;
      done = 1'b0;
      while (!done) begin
        exp_lane[exp_n] = 2'(l);
        exp_d[exp_n]    = wd[l][rp[l]];
        exp_last[exp_n] = wl[l][rp[l]];
        done = wl[l][rp[l]];
        rp[l]++;
        n++;
        exp_n++;
        if (n >= MB || rp[l] >= wcnt[l]) done = 1'b1;
      end
      p = (l + 1) % NL;
    end
  endtask

  task automatic compare_model(input string nm);
    bit ok;
    int m;
    c({nm, " count"}, obs_n, exp_n);
    m = (obs_n < exp_n) ? obs_n : exp_n;
    for (int k = 0; k < m; k++) begin
      chk($sformatf("%s lane[%0d]", nm, k), obs_lane[k], exp_lane[k], ok);
      if (!ok) break;
      chk($sformatf("%s last[%0d]", nm, k), obs_last[k], exp_last[k], ok);
      if (!ok) break;
      chk($sformatf("%s code[%0d]", nm, k), obs_code[k],
          enc_f(exp_d[k]), ok);
      if (!ok) break;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] rr_exp[9];
    logic [1:0] dr_exp[7];
    logic [7:0] dr_dat[7];
    logic [1:0] mb_l;
    int rst_idx;
    int k;

    rr_exp = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    dr_exp = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    dr_dat = '{8'h50, 8'h51, 8'h60, 8'h61, 8'h52, 8'h53, 8'h54};

    //          rst  v    d     l   busy rdy  enc   cv  lane last cd
    tv[0] = '{1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[1] = '{1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[2] = '{1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[3] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[4] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[5] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[6] = '{1'b0, 4'h4, 8'h05, 1'b1, 1'b1, 4'h4, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[7] = '{1'b0, 4'h4, 8'h05, 1'b1, 1'b0, 4'h0, 8'h05, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[8] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h05, 1'b1, 2'd2, 1'b1, 8'h05};
    tv[9] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h05, 1'b0, 2'd0, 1'b0, 8'h05};

    reset = 1'b1;
    repeat (2) @(posedge clock);
    for (int r = 0; r < 10; r++) begin
      reset     = tv[r].rst;
      req_valid = tv[r].v;
      req_data  = {4{tv[r].d}};
      req_last  = {4{tv[r].l}};
      @(posedge clock);
      @(negedge clock);
      c($sformatf("tv%0d busy", r), busy, tv[r].busy);
      c($sformatf("tv%0d ready", r), req_ready, tv[r].rdy);
      c($sformatf("tv%0d enc_datain", r), enc_datain, tv[r].enc);
      c($sformatf("tv%0d code_valid", r), code_valid, tv[r].cv);
      c($sformatf("tv%0d code_lane", r), code_lane, tv[r].lane);
      c($sformatf("tv%0d code_last", r), code_last, tv[r].last);
      c($sformatf("tv%0d code_out", r), code_out, enc_f(tv[r].cd));
    end

    // round robin over lanes 0,1,3
    clear_lanes();
    add_packet(0, 3, 8'h00, 1'b0);
    add_packet(1, 3, 8'h10, 1'b0);
    add_packet(3, 3, 8'h30, 1'b0);
    build_model();
    do_reset();
    run_until(9, 100);
    compare_model("rr");
    for (int i = 0; i < 9; i++) begin
      c($sformatf("rr lane seq[%0d]", i), obs_lane[i], rr_exp[i]);
      c($sformatf("rr last seq[%0d]", i), obs_last[i], (i % 3) == 2);
    end
    c("rr in-burst spacing", obs_cyc[1] - obs_cyc[0], 1);
    c("rr bubble 0->1", obs_cyc[3] - obs_cyc[2], 2);
    c("rr bubble 1->3", obs_cyc[6] - obs_cyc[5], 2);

    // MAX_BURST cap with two 10-word packets
    clear_lanes();
    add_packet(0, 10, 8'h00, 1'b0);
    add_packet(1, 10, 8'h40, 1'b0);
    build_model();
    do_reset();
    run_until(20, 200);
    compare_model("maxburst");
    for (int i = 0; i < 20; i++) begin
      mb_l = (i < 8) ? 2'd0 : (i < 16) ? 2'd1 : (i < 18) ? 2'd0 : 2'd1;
      c($sformatf("maxburst lane[%0d]", i), obs_lane[i], mb_l);
    end

    // lane 1 drops valid after 2 words while lane 2 waits
    clear_lanes();
    add_packet(1, 5, 8'h50, 1'b0);
    add_packet(2, 2, 8'h60, 1'b0);
    drop_on = 1'b1;
    do_reset();
    run_until(7, 100);
    c("drop count", obs_n, 7);
    for (int i = 0; i < 7; i++) begin
      c($sformatf("drop lane[%0d]", i), obs_lane[i], dr_exp[i]);
      c($sformatf("drop code[%0d]", i), obs_code[i], enc_f(dr_dat[i]));
    end
    c("drop spacing", obs_cyc[1] - obs_cyc[0], 1);
    c("drop gap", obs_cyc[2] - obs_cyc[1], 3);
    c("drop hold a", enc_hist[obs_cyc[1]], 8'h51);
    c("drop hold b", enc_hist[obs_cyc[1] + 1], 8'h51);
    drop_on = 1'b0;

    // reset one cycle after an accept
    clear_lanes();
    add_packet(2, 3, 8'h70, 1'b0);
    do_reset();
    k = 0;
    while (wptr[2] < 1 && k < 30) begin
      cycle();
      k++;
    end
    c("rst accept seen", wptr[2], 1);
    reset = 1'b1;
    pend  = '0;
    add_packet(0, 2, 8'h80, 1'b0);
    rst_idx = cyc;
    cycle();
    reset = 1'b0;
    run_until(4, 100);
    c("rst pre enc", enc_hist[rst_idx - 1], 8'h70);
    c("rst enc0", enc_hist[rst_idx], 8'h00);
    c("rst prime0", enc_hist[rst_idx + 1], 8'h00);
    c("rst prime1", enc_hist[rst_idx + 2], 8'h00);
    c("rst count", obs_n, 4);
    c("rst first lane", obs_lane[0], 2'd0);
    c("rst first code", obs_code[0], enc_f(8'h80));
    c("rst lane2 code", obs_code[2], enc_f(8'h71));
    c("rst lane2 last", obs_code[3], enc_f(8'h72));

    // randomized packets against the transaction model
    for (int it = 0; it < 4; it++) begin
      clear_lanes();
      for (int l = 0; l < 4; l++) begin
        k = $urandom_range(0, 3);
        for (int p = 0; p < k; p++)
          add_packet(l, $urandom_range(1, 12), 8'h00, 1'b1);
      end
      build_model();
      do_reset();
      run_until(exp_n, exp_n * 3 + 40);
      compare_model($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
